// File: rtl/reverse_pkg.sv
//------------------------------------------------------------------------------
// Module   : reverse_pkg
// Brief    : Shared types and width-generic reverse helpers for reverse_arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package reverse_pkg;

  // Upper bound on operand width handled by the helpers; callers zero-extend.
  localparam int REV_MAXW = 512;

  typedef enum logic {
    OP_BIT  = 1'b0,
    OP_BYTE = 1'b1
  } op_e;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // result[i] = d[w-1-i] for i < w; bits at and above w are zero.
  function automatic logic [REV_MAXW-1:0] bitrev(input logic [REV_MAXW-1:0] d,
                                                 input int w);
    logic [REV_MAXW-1:0] r;
    r = '0;
    for (int i = 0; i < REV_MAXW; i++) begin
      if (i < w) r[i] = d[w-1-i];
    end
    return r;
  endfunction

  // result byte k = d byte (w/8-1-k) for k < w/8; remaining bytes are zero.
  function automatic logic [REV_MAXW-1:0] byterev(input logic [REV_MAXW-1:0] d,
                                                  input int w);
    logic [REV_MAXW-1:0] r;
    r = '0;
    for (int k = 0; k < REV_MAXW/8; k++) begin
      if (k < w/8) r[8*k +: 8] = d[8*(w/8-1-k) +: 8];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reverse_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : reverse_rr_arbiter
// Brief    : Round-robin pick; search starts one past last_grant, first hit wins.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reverse_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  logic w_found;

  always_comb begin : p_search
    int c;
    gnt     = '0;
    idx     = '0;
    w_found = 1'b0;
    c       = 0;
    for (int off = 1; off <= NREQ; off++) begin
      c = int'(last_grant) + off;
      if (c >= NREQ) c = c - NREQ;
      if (!w_found && req[c]) begin
        w_found = 1'b1;
        gnt[c]  = 1'b1;
        idx     = IDW'(c);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/reverse_arbiter.sv
//------------------------------------------------------------------------------
// Module   : reverse_arbiter
// Brief    : NREQ requesters share one bit/byte reverse unit behind a single
//            output register. Define REVERSE_ARBITER_BYTE_EN to honour req_op.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reverse_arbiter
  import reverse_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREQ = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_vld,
  output logic [NREQ-1:0]         req_rdy,
  input  logic [NREQ*XLEN-1:0]    req_dat,
  input  logic [NREQ-1:0]         req_op,
  output logic                    rsp_vld,
  input  logic                    rsp_rdy,
  output logic [XLEN-1:0]         rsp_dat,
  output logic [$clog2(NREQ)-1:0] rsp_id
);

  localparam int IDW = $clog2(NREQ);

  generate
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("reverse_arbiter: NREQ must be in 2..8");
    end
    if (XLEN < 1 || XLEN >= REV_MAXW) begin : g_bad_xlen
      $error("reverse_arbiter: XLEN out of supported range");
    end
`ifdef REVERSE_ARBITER_BYTE_EN
    if (XLEN % 8 != 0) begin : g_bad_xlen_byte
      $error("reverse_arbiter: XLEN must be a multiple of 8 for byte reverse");
    end
`endif
  endgenerate

  state_e              r_state;
  state_e              w_state_nxt;
  logic [IDW-1:0]      r_last_grant;
  logic [XLEN-1:0]     r_rsp_dat;
  logic [IDW-1:0]      r_rsp_id;

  logic [NREQ-1:0]     w_gnt;
  logic [IDW-1:0]      w_gnt_idx;
  logic                w_can_accept;
  logic [NREQ-1:0]     w_req_rdy;
  logic                w_xfer;
  logic [XLEN-1:0]     w_sel_dat;
  logic [REV_MAXW-1:0] w_rev_full;
  logic [XLEN-1:0]     w_rev;
  logic                w_unused_rev;

  reverse_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req        (req_vld),
    .last_grant (r_last_grant),
    .gnt        (w_gnt),
    .idx        (w_gnt_idx)
  );

  assign w_sel_dat = req_dat[w_gnt_idx*XLEN +: XLEN];

`ifdef REVERSE_ARBITER_BYTE_EN
  op_e w_sel_op;
  assign w_sel_op = op_e'(req_op[w_gnt_idx]);

  always_comb begin
    if (w_sel_op == OP_BYTE) w_rev_full = byterev(REV_MAXW'(w_sel_dat), XLEN);
    else                     w_rev_full = bitrev(REV_MAXW'(w_sel_dat), XLEN);
  end
`else
  logic w_unused_op;
  assign w_unused_op = ^req_op;

  always_comb begin
    w_rev_full = bitrev(REV_MAXW'(w_sel_dat), XLEN);
  end
`endif

  assign w_rev        = w_rev_full[XLEN-1:0];
  assign w_unused_rev = ^w_rev_full[REV_MAXW-1:XLEN];

  // Output-register FSM: state flop here, next-state and handshake below.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_can_accept = 1'b0;
    w_req_rdy    = '0;
    w_xfer       = 1'b0;

    w_can_accept = (r_state == ST_EMPTY) || rsp_rdy;
    // Ready is forced low during reset so nothing is taken in that cycle.
    w_req_rdy    = w_gnt & {NREQ{w_can_accept && !rst}};
    w_xfer       = |(req_vld & w_req_rdy);

    case (r_state)
      ST_EMPTY: if (w_xfer) w_state_nxt = ST_FULL;
      ST_FULL:  if (rsp_rdy && !w_xfer) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // Result and priority pointer move only on an accepted transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_dat    <= '0;
      r_rsp_id     <= '0;
      r_last_grant <= IDW'(NREQ-1);
    end else if (w_xfer) begin
      r_rsp_dat    <= w_rev;
      r_rsp_id     <= w_gnt_idx;
      r_last_grant <= w_gnt_idx;
    end
  end

  assign req_rdy = w_req_rdy;
  assign rsp_vld = (r_state == ST_FULL);
  assign rsp_dat = r_rsp_dat;
  assign rsp_id  = r_rsp_id;

endmodule

`default_nettype wire
